// File: rtl/dfs_tree_walker.sv
// Depth-first walker for the packet-classification decision tree; drives the node-index stack
// and reports the lowest matching rule_id. Define DFS_WALKER_STATS_EN to add visit/push counters.
module dfs_tree_walker #(
  parameter int NODE_IDX_W = 8,
  parameter int RULE_W     = 16,
  parameter int ROOT_IDX   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [NODE_IDX_W-1:0] node_addr,
  output logic                  node_rd,
  input  logic                  node_is_leaf,
  input  logic [RULE_W-1:0]     node_rule,
  input  logic [NODE_IDX_W-1:0] node_left,
  input  logic [NODE_IDX_W-1:0] node_right,
  input  logic [1:0]            child_match,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [NODE_IDX_W-1:0] stk_din,
  input  logic [NODE_IDX_W-1:0] stk_dout,
  input  logic                  stk_just_popped,
  input  logic                  stk_full,
  input  logic                  stk_empty,
  output logic                  busy,
  output logic                  done,
  output logic                  match_found,
  output logic [RULE_W-1:0]     best_rule,
  output logic                  overflow_err
`ifdef DFS_WALKER_STATS_EN
  ,
  output logic [15:0]           nodes_visited,
  output logic [NODE_IDX_W:0]   pushes
`endif
);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, EVAL, POP, POP_WAIT, FINISH
  } state_t;

  localparam logic [NODE_IDX_W-1:0] ROOT = NODE_IDX_W'(ROOT_IDX);

  state_t                state, next_state;
  logic [NODE_IDX_W-1:0] cur;
  logic [RULE_W-1:0]     best;

  // Fetched node, captured in WAIT and used throughout EVAL.
  logic                  n_leaf;
  logic [RULE_W-1:0]     n_rule;
  logic [NODE_IDX_W-1:0] n_left;
  logic [NODE_IDX_W-1:0] n_right;
  logic [1:0]            n_match;

  logic                  path_end;
  logic                  fork_node;
  logic [RULE_W-1:0]     eval_best;
  logic                  eval_match;

  // A leaf and a dead-end internal node both end the current path.
  assign path_end   = n_leaf || (n_match == 2'b00);
  assign fork_node  = !n_leaf && (n_match == 2'b11);
  assign eval_best  = (n_leaf && (n_rule < best)) ? n_rule : best;
  assign eval_match = match_found || n_leaf;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets a default first so no path through the case infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (start) next_state = FETCH;
      FETCH:    next_state = WAIT;
      WAIT:     next_state = EVAL;
      EVAL: begin
        if (path_end)                   next_state = stk_empty ? FINISH : POP;
        else if (fork_node && stk_full) next_state = FINISH;
        else                            next_state = FETCH;
      end
      POP:      next_state = POP_WAIT;
      POP_WAIT: if (stk_just_popped) next_state = FETCH;
      FINISH:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    node_addr = cur;
    node_rd   = (state == FETCH);
    stk_push  = (state == EVAL) && fork_node && !stk_full;
    stk_pop   = (state == POP);
    stk_din   = n_right;
    busy      = (state != IDLE) && (state != FINISH);
    done      = (state == FINISH);
  end

  // NOTE: every datapath register is reset because the result outputs must read 0 straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur          <= ROOT;
      best         <= '1;
      n_leaf       <= 1'b0;
      n_rule       <= '0;
      n_left       <= '0;
      n_right      <= '0;
      n_match      <= 2'b00;
      match_found  <= 1'b0;
      overflow_err <= 1'b0;
      best_rule    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cur          <= ROOT;
            best         <= '1;
            match_found  <= 1'b0;
            overflow_err <= 1'b0;
            best_rule    <= '0;
          end
        end
        WAIT: begin
          n_leaf  <= node_is_leaf;
          n_rule  <= node_rule;
          n_left  <= node_left;
          n_right <= node_right;
          n_match <= child_match;
        end
        EVAL: begin
          best        <= eval_best;
          match_found <= eval_match;
          if (!path_end) begin
            unique case (n_match)
              2'b11: begin
                if (stk_full) overflow_err <= 1'b1;
                else          cur          <= n_left;
              end
              2'b01:   cur <= n_left;
              2'b10:   cur <= n_right;
              default: cur <= cur;
            endcase
          end
          // Publish the result on the way into FINISH so it is valid alongside done.
          if (next_state == FINISH) best_rule <= eval_match ? eval_best : '0;
        end
        POP_WAIT: if (stk_just_popped) cur <= stk_dout;
        default: ;
      endcase
    end
  end

`ifdef DFS_WALKER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      nodes_visited <= '0;
      pushes        <= '0;
    end else if (state == IDLE && start) begin
      nodes_visited <= '0;
      pushes        <= '0;
    end else begin
      if (state == EVAL && nodes_visited != 16'hFFFF) nodes_visited <= nodes_visited + 16'd1;
      if (stk_push && pushes != '1)                   pushes        <= pushes + 1'b1;
    end
  end
`endif

endmodule

// File: doc/dfs_tree_walker.md
Name: dfs_tree_walker

Overview:
- Depth-first traversal controller for the packet-classification decision tree.
- Sits directly upstream of the node-index stack: drives its push/pop/data_in and consumes its data_out/just_popped/full/empty.
- Walks every matching branch from the root, fetching nodes from node memory, and reports the highest-priority matching rule. Lowest rule_id wins.

Parameters:
- NODE_IDX_W, 8, node index width; equals the stack DATA_WIDTH.
- RULE_W, 16, rule identifier width.
- ROOT_IDX, 0, node index where every traversal starts.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begin traversal (ignored unless IDLE)
- node_addr  out  NODE_IDX_W  node memory read address
- node_rd  out  1  node memory read strobe
- node_is_leaf  in  1  fetched node is a leaf; valid 1 cycle after node_rd
- node_rule  in  RULE_W  leaf rule_id
- node_left  in  NODE_IDX_W  left child index
- node_right  in  NODE_IDX_W  right child index
- child_match  in  2  [0] left child matches packet, [1] right child matches packet; from external matcher, same timing as node data
- stk_push  out  1  stack push
- stk_pop  out  1  stack pop
- stk_din  out  NODE_IDX_W  index to push
- stk_dout  in  NODE_IDX_W  popped index
- stk_just_popped  in  1  stk_dout valid this cycle
- stk_full  in  1  stack full
- stk_empty  in  1  stack empty
- busy  out  1  traversal in progress
- done  out  1  one-cycle pulse at completion
- match_found  out  1  at least one leaf visited; held until next start
- best_rule  out  RULE_W  lowest leaf rule_id seen; held until next start
- overflow_err  out  1  push attempted while stk_full; held until next start

Behaviour:
- Reset values: all outputs 0; state IDLE; internal best register all-ones.
- States: IDLE, FETCH, WAIT, EVAL, POP, POP_WAIT, FINISH.
- IDLE:
  - On start, clear match_found, overflow_err and best (all-ones).
  - Set cur = ROOT_IDX, busy = 1, go to FETCH.
- FETCH: node_addr = cur, node_rd = 1 for exactly 1 cycle, then WAIT.
- WAIT: node data and child_match are valid in this cycle; register them, then EVAL.
  - Fixed 2-cycle fetch latency measured from FETCH.
- EVAL, leaf node:
  - If node_rule < best, set best = node_rule.
  - Set match_found = 1. Leaves with equal rule_id do not change best.
  - Then go to POP if !stk_empty, else FINISH.
- EVAL, internal node:
  - child_match = 2'b11: if stk_full, set overflow_err = 1 and go to FINISH. Otherwise pulse stk_push with stk_din = node_right, set cur = node_left, go to FETCH.
  - child_match = 2'b01: cur = node_left, FETCH. No push.
  - child_match = 2'b10: cur = node_right, FETCH. No push.
  - child_match = 2'b00: dead end; same exit as a leaf (POP or FINISH).
- POP: stk_pop = 1 for exactly 1 cycle, then POP_WAIT.
- POP_WAIT: wait for stk_just_popped, then cur = stk_dout, go to FETCH.
  - The stack guarantees just_popped on the cycle after a non-empty pop.
- FINISH:
  - best_rule = best if match_found, else 0.
  - Pulse done for 1 cycle; busy = 0; return to IDLE.
- stk_push and stk_pop are never asserted in the same cycle. Each is a single-cycle pulse.
- start while busy is ignored.
- Reset mid-traversal returns to IDLE within the same edge.
  - The stack shares the reset, so no stale entries survive.
- Comparison of node_rule against best is unsigned, RULE_W bits. No arithmetic overflow is possible.

Optional Feature:
- Macro: DFS_WALKER_STATS_EN.
- Defined:
  - Adds output nodes_visited (16 bits): counts EVAL cycles and saturates at 16'hFFFF.
  - Adds output pushes (NODE_IDX_W+1 bits): counts push pulses, saturating.
  - Both clear on start and on reset, and hold after done.
- Not defined: neither port exists and there is no counter logic.

Test Plan:
- Root is a leaf, rule 7; start -> done 4 cycles after start; match_found=1, best_rule=7, no stack traffic.
- Root with child_match=01, left child a leaf with rule 3 -> no push; best_rule=3; done.
- Root with child_match=11, left leaf rule 9, right leaf rule 4 -> one push of the right index, one pop; best_rule=4 (lower wins); stk_empty at done.
- Tree with no matching path (root child_match=00) -> match_found=0, best_rule=0, done pulses once.
- Stack model held full, root child_match=11 -> overflow_err=1, done, no stk_push pulse.
- Reset asserted in POP_WAIT, then start on a single-leaf tree with rule 5 -> traversal restarts cleanly; best_rule=5; no stale pop consumed.
